// File: rtl/frame_window_buffer.sv
// Sliding window of the last NUM_FRAMES sensor frames for the gesture Core.
// Samples are assembled channel by channel into a staging frame. A complete
// frame is committed into the window only when the Core signals i_ready.
module frame_window_buffer #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned NUM_FRAMES = 5,
    parameter int unsigned DW         = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,  // active-high synchronous reset
    input  logic          i_clear,
    input  logic          i_valid,
    input  logic [DW-1:0] i_sample,
    output logic          o_ready,
    input  logic          i_ready,
    output logic [DW-1:0] o_data [0:NUM_FRAMES*NUM_CH-1],
    output logic          o_next,
    output logic [2:0]    o_fill,
    output logic [15:0]   o_frame_cnt
);

    localparam int unsigned NumEntries = NUM_FRAMES * NUM_CH;
    localparam int unsigned ChW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ChW-1:0] ChLast  = ChW'(NUM_CH - 1);
    localparam logic [2:0]     FillMax = 3'(NUM_FRAMES);

    typedef enum logic [0:0] {
        StCollect,
        StPending
    } state_e;

    state_e         state_q;
    logic [ChW-1:0] ch_q;
    logic [DW-1:0]  stage_q  [0:NUM_CH-1];
    logic [DW-1:0]  window_q [0:NumEntries-1];
    logic           next_q;
    logic [2:0]     fill_q;
    logic [15:0]    cnt_q;

    // Frame assembly, commit into the window, fill and frame counting.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            state_q <= StCollect;
            ch_q    <= '0;
            next_q  <= 1'b0;
            fill_q  <= '0;
            cnt_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) stage_q[c] <= '0;
            for (int i = 0; i < NumEntries; i++) window_q[i] <= '0;
        end else if (i_clear) begin
            // Frame counter survives a clear; everything else is flushed.
            state_q <= StCollect;
            ch_q    <= '0;
            next_q  <= 1'b0;
            fill_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) stage_q[c] <= '0;
            for (int i = 0; i < NumEntries; i++) window_q[i] <= '0;
        end else begin
            next_q <= 1'b0;
            unique case (state_q)
                StCollect: begin
                    if (i_valid) begin
                        stage_q[ch_q] <= i_sample;
                        if (ch_q == ChLast) begin
                            ch_q    <= '0;
                            state_q <= StPending;
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end
                end
                StPending: begin
                    if (i_ready) begin
                        // Oldest frame drops out, staged frame becomes newest.
                        for (int i = 0; i < NumEntries - NUM_CH; i++) begin
                            window_q[i] <= window_q[i+NUM_CH];
                        end
                        for (int c = 0; c < NUM_CH; c++) begin
                            window_q[NumEntries-NUM_CH+c] <= stage_q[c];
                        end
                        fill_q  <= (fill_q == FillMax) ? fill_q : fill_q + 3'd1;
                        cnt_q   <= cnt_q + 16'd1;
                        // Post-commit fill is full iff pre-commit fill >= NUM_FRAMES-1.
                        next_q  <= (fill_q >= FillMax - 3'd1);
                        state_q <= StCollect;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    // Outputs are direct views of registered state.
    always_comb begin
        o_ready     = (state_q == StCollect);
        o_next      = next_q;
        o_fill      = fill_q;
        o_frame_cnt = cnt_q;
        for (int i = 0; i < NumEntries; i++) o_data[i] = window_q[i];
    end

endmodule

// File: tb/tb_frame_window_buffer.sv
// Self-checking bench for frame_window_buffer: directed vector table,
// test-plan sequences and random traffic against a queue-based window model.
module tb_frame_window_buffer;

    localparam int NCH = 8;
    localparam int NFR = 5;
    localparam int NE  = NCH * NFR;

    logic        clk = 1'b0;
    logic        rst, clr, valid, rdy;
    logic [15:0] sample;
    logic        ready, nxt;
    logic [15:0] data [0:NE-1];
    logic [2:0]  fill;
    logic [15:0] cnt;

    always #5 clk = ~clk;

    frame_window_buffer #(
        .NUM_CH    (NCH),
        .NUM_FRAMES(NFR),
        .DW        (16)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clear    (clr),
        .i_valid    (valid),
        .i_sample   (sample),
        .o_ready    (ready),
        .i_ready    (rdy),
        .o_data     (data),
        .o_next     (nxt),
        .o_fill     (fill),
        .o_frame_cnt(cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: window is a queue of whole frames, oldest first.
    typedef logic [NCH*16-1:0] frame_t;
    frame_t      win_q[$];
    frame_t      stage_m;
    int          ch_m;
    bit          pend_m;
    bit          next_m;
    logic [15:0] cnt_m;

    function automatic logic [15:0] exp_entry(int idx);
        int     f = idx / NCH;
        int     c = idx % NCH;
        int     n = win_q.size();
        frame_t fr;
        if (f < NFR - n) return 16'h0000;
        fr = win_q[f-(NFR-n)];
        return fr[c*16 +: 16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            win_q.delete();
            stage_m = '0; ch_m = 0; pend_m = 0; next_m = 0; cnt_m = 16'h0;
        end else if (clr) begin
            win_q.delete();
            stage_m = '0; ch_m = 0; pend_m = 0; next_m = 0;
        end else begin
            next_m = 0;
            if (pend_m) begin
                if (rdy) begin
                    win_q.push_back(stage_m);
                    if (win_q.size() > NFR) void'(win_q.pop_front());
                    cnt_m  = cnt_m + 16'd1;
                    pend_m = 0;
                    next_m = (win_q.size() == NFR);
                end
            end else if (valid) begin
                stage_m[ch_m*16 +: 16] = sample;
                ch_m++;
                if (ch_m == NCH) begin
                    ch_m   = 0;
                    pend_m = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int bad = -1;
        check("o_ready", {31'b0, ready}, {31'b0, !pend_m});
        check("o_next", {31'b0, nxt}, {31'b0, next_m});
        check("o_fill", {29'b0, fill}, 32'(win_q.size()));
        check("o_frame_cnt", {16'b0, cnt}, {16'b0, cnt_m});
        for (int i = 0; i < NE; i++) begin
            if (bad < 0 && data[i] !== exp_entry(i)) bad = i;
        end
        if (bad < 0) bad = NE - 1;
        check($sformatf("o_data[%0d]", bad), {16'b0, data[bad]}, {16'b0, exp_entry(bad)});
    endtask

    // One clock: drive, let the edge happen, advance the model, compare at negedge.
    task automatic cycle(input logic r, input logic c, input logic v, input logic [15:0] s,
                         input logic y);
        rst = r; clr = c; valid = v; sample = s; rdy = y;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic send_frame(input int k, input logic y_commit);
        for (int c = 0; c < NCH; c++) cycle(1'b0, 1'b0, 1'b1, 16'(k * 16 + c), 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'hDEAD, y_commit);
    endtask

    typedef struct {
        logic        rst, clr, valid;
        logic [15:0] sample;
        logic        rdy;
        logic        exp_ready, exp_next;
        logic [2:0]  exp_fill;
        logic [15:0] exp_cnt;
        logic [15:0] exp_d39;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int t5;
        rst = 1'b1; clr = 1'b0; valid = 1'b0; sample = '0; rdy = 1'b0;

        // Directed vector table: expected values after the edge.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 16'h0000};
        for (int i = 1; i <= 8; i++) begin
            vecs[i] = '{1'b0, 1'b0, 1'b1, 16'(16'hFF80 + i - 1), 1'b0,
                        (i < 8), 1'b0, 3'd0, 16'd0, 16'h0000};
        end
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd1, 16'd1, 16'hFF87};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 3'd0, 16'd1, 16'h0000};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 16'h0000};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rst, vecs[i].clr, vecs[i].valid, vecs[i].sample, vecs[i].rdy);
            check($sformatf("vec%0d ready", i), {31'b0, ready}, {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d next", i), {31'b0, nxt}, {31'b0, vecs[i].exp_next});
            check($sformatf("vec%0d fill", i), {29'b0, fill}, {29'b0, vecs[i].exp_fill});
            check($sformatf("vec%0d cnt", i), {16'b0, cnt}, {16'b0, vecs[i].exp_cnt});
            check($sformatf("vec%0d d39", i), {16'b0, data[39]}, {16'b0, vecs[i].exp_d39});
        end

        // Fill the window: frames 1..4 give no o_next, frame 5 does.
        for (int k = 1; k <= 4; k++) send_frame(k, 1'b1);
        check("fill4", {29'b0, fill}, 32'd4);
        check("f1 ch0 at 8", {16'b0, data[8]}, 32'h0010);
        check("f1 ch7 at 15", {16'b0, data[15]}, 32'h0017);
        send_frame(5, 1'b1);
        t5 = cyc;
        check("next f5", {31'b0, nxt}, 32'd1);
        check("d0 f5", {16'b0, data[0]}, 32'h0010);
        check("d39 f5", {16'b0, data[39]}, 32'h0057);
        check("cnt f5", {16'b0, cnt}, 32'd5);
        send_frame(6, 1'b1);
        check("next f6", {31'b0, nxt}, 32'd1);
        check("next gap", 32'(cyc - t5), 32'd9);
        check("d0 f6", {16'b0, data[0]}, 32'h0020);
        check("d32 f6", {16'b0, data[32]}, 32'h0060);

        // Negative samples pass through unchanged.
        for (int c = 0; c < NCH; c++) cycle(1'b0, 1'b0, 1'b1, 16'(16'hFF80 + c), 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        check("neg d32", {16'b0, data[32]}, 32'h0000FF80);
        check("neg d39", {16'b0, data[39]}, 32'h0000FF87);

        // Back-pressure: frame completes, Core stalls 20 cycles, then commits.
        for (int c = 0; c < NCH; c++) cycle(1'b0, 1'b0, 1'b1, 16'(16'h0080 + c), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 16'h0090, 1'b0);
            check("stall ready", {31'b0, ready}, 32'd0);
            check("stall d39", {16'b0, data[39]}, 32'h0000FF87);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h0090, 1'b1);
        check("stall commit next", {31'b0, nxt}, 32'd1);
        check("stall commit d39", {16'b0, data[39]}, 32'h0087);
        for (int c = 0; c < NCH; c++) cycle(1'b0, 1'b0, 1'b1, 16'(16'h0090 + c), 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        check("post-stall d32", {16'b0, data[32]}, 32'h0090);

        // Clear in the middle of a frame with a full window.
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b1, 16'(16'h00A0 + c), 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 16'h00A3, 1'b1);
        check("clear fill", {29'b0, fill}, 32'd0);
        check("clear d39", {16'b0, data[39]}, 32'd0);
        check("clear cnt", {16'b0, cnt}, 32'd9);
        for (int k = 1; k <= 4; k++) begin
            send_frame(k + 16, 1'b1);
            check("post-clear no next", {31'b0, nxt}, 32'd0);
        end
        send_frame(21, 1'b1);
        check("post-clear next", {31'b0, nxt}, 32'd1);
        check("post-clear d0", {16'b0, data[0]}, 32'h0110);

        // Reset while a frame is pending: nothing commits.
        for (int c = 0; c < NCH; c++) cycle(1'b0, 1'b0, 1'b1, 16'(c), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("rst pend cnt", {16'b0, cnt}, 32'd0);
        check("rst pend fill", {29'b0, fill}, 32'd0);
        check("rst pend ready", {31'b0, ready}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        check("rst pend next", {31'b0, nxt}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
